// File: rtl/sized_dmem_pkg.sv
// -----------------------------------------------------------------------------
// sized_dmem_pkg
// Shared types and helpers for the sized data memory:
//   size_e    - access size encoding (byte/half/word/double)
//   state_e   - controller state (hardware clear sequence, normal run)
//   byte_mask - byte-lane enable mask for a given size and byte offset
// -----------------------------------------------------------------------------
package sized_dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Widest supported word is 64 bits, so masks are at most 8 lanes wide.
    localparam int MAX_LANES = 8;

    // Lanes offset .. offset + 2^size - 1 set. Lanes shifted past the top of
    // the word fall off; callers only pass naturally aligned offsets or
    // offsets already range-checked for the word width.
    function automatic logic [MAX_LANES-1:0] byte_mask(input logic [1:0] size,
                                                       input logic [2:0] offset);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << offset;
        return m[MAX_LANES-1:0];
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// -----------------------------------------------------------------------------
// dmem_load_extend
// Purely combinational load alignment: shifts the read word right by the byte
// offset, truncates to the access size and sign- or zero-extends to XLEN.
// Ports:
//   word        in  XLEN  raw word read from the array
//   offset      in  OFF   byte offset inside the word (already aligned)
//   size        in  2     access size (size_e encoding)
//   is_unsigned in  1     1 = zero-extend, 0 = sign-extend
//   data        out XLEN  extended load result
// -----------------------------------------------------------------------------
module dmem_load_extend
    import sized_dmem_pkg::*;
#(
    parameter  int XLEN = 64,
    localparam int OFF  = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] word,
    input  logic [OFF-1:0]  offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic [63:0]     wide;
    logic [63:0]     res;
    logic            sgn;

    // Work in a fixed 64-bit domain so the same extension code serves both
    // XLEN settings; the result is then cut back to XLEN.
    always_comb begin
        shifted = word >> {offset, 3'b000};
        wide    = 64'(shifted);
        sgn     = 1'b0;
        res     = wide;
        case (size_e'(size))
            SZ_B: begin
                sgn = ~is_unsigned & wide[7];
                res = {{56{sgn}}, wide[7:0]};
            end
            SZ_H: begin
                sgn = ~is_unsigned & wide[15];
                res = {{48{sgn}}, wide[15:0]};
            end
            SZ_W: begin
                sgn = ~is_unsigned & wide[31];
                res = {{32{sgn}}, wide[31:0]};
            end
            SZ_D: begin
                // Full word regardless of offset or signedness.
                res = 64'(word);
            end
            default: res = wide;
        endcase
        data = res[XLEN-1:0];
    end

endmodule

// File: rtl/sized_data_memory.sv
// -----------------------------------------------------------------------------
// sized_data_memory
// Byte-addressed single-port synchronous data RAM for RISC-V loads/stores of
// byte/half/word/double size with sign or zero extension. After every reset a
// hardware clear sequence writes zero to every word before requests are
// accepted. Responses come exactly one cycle after the accepting edge.
//
// Parameters: XLEN (32 or 64), DEPTH (words, power of two >= 2).
// Ports:
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request accepted this cycle when high
//   req_we       in   1 = store, 0 = load
//   req_addr     in   byte address (wraps modulo DEPTH*XLEN/8)
//   req_size     in   0 byte, 1 half, 2 word, 3 double
//   req_unsigned in   zero-extend the load
//   req_wdata    in   store data, low bytes used
//   rsp_valid    out  one-cycle response pulse per accepted request
//   rsp_rdata    out  extended load data, 0 for stores/errors/idle
//   rsp_err      out  request rejected
//
// Build option: SIZED_DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned requests are rejected (rsp_err, no array write)
//   undefined - misaligned offsets are aligned down and performed
// -----------------------------------------------------------------------------
module sized_data_memory
    import sized_dmem_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    // Controller state
    state_e          state_reg;
    logic [AW-1:0]   clr_idx_reg;
    logic            req_ready_reg;

    // Response pipeline state
    logic            rsp_valid_reg;
    logic            rsp_err_reg;
    logic            rsp_load_reg;
    logic            rsp_uns_reg;
    logic [1:0]      rsp_size_reg;
    logic [OFF-1:0]  rsp_off_reg;

    // Request decode
    logic [AW-1:0]        word_idx;
    logic [OFF-1:0]       byte_off;
    logic [OFF-1:0]       align_mask;
    logic [OFF-1:0]       eff_off;
    logic                 size_illegal;
    logic                 req_err;
    logic                 accept;
    logic                 do_write;
    logic                 rd_en;
    logic [MAX_LANES-1:0] full_mask;

    // Array write port
    logic [AW-1:0]   mem_idx;
    logic [NB-1:0]   lane_we;
    logic [XLEN-1:0] lane_wdata;

    // Array read data and extended result
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] ext_data;

    assign word_idx = req_addr[OFF +: AW];
    assign byte_off = req_addr[OFF-1:0];
    assign accept   = req_valid && req_ready_reg;

    always_comb begin
        align_mask   = OFF'((4'd1 << req_size) - 4'd1);
        size_illegal = (XLEN == 32) && (req_size == 2'd3);
`ifdef SIZED_DMEM_MISALIGN_TRAP_EN
        eff_off      = byte_off;
        req_err      = size_illegal || ((byte_off & align_mask) != '0);
`else
        // Natural alignment down: drop the offset bits below the size.
        eff_off      = byte_off & ~align_mask;
        req_err      = size_illegal;
`endif
        full_mask    = byte_mask(req_size, 3'(eff_off));
        do_write     = accept && req_we && !req_err;
        rd_en        = accept && !req_we;
    end

    // The clear sequence owns the write port while in INIT; requests cannot
    // be accepted then, so there is no conflict with stores.
    always_comb begin
        if (state_reg == ST_INIT) begin
            mem_idx    = clr_idx_reg;
            lane_we    = '1;
            lane_wdata = '0;
        end else begin
            mem_idx    = word_idx;
            lane_we    = do_write ? full_mask[NB-1:0] : '0;
            lane_wdata = req_wdata << {eff_off, 3'b000};
        end
    end

    // One byte-wide RAM per lane, each with its own registered read, so the
    // byte enables map directly onto independent memories.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_q_reg;

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[mem_idx] <= lane_wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_q_reg <= lane_mem[word_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_q_reg;
        end
    endgenerate

    // Clear sequence: one word per edge, ready rises on the edge that clears
    // the last word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_INIT;
            clr_idx_reg   <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    clr_idx_reg <= clr_idx_reg + AW'(1);
                    if (clr_idx_reg == AW'(DEPTH - 1)) begin
                        state_reg     <= ST_RUN;
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_INIT;
                    clr_idx_reg   <= '0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Response bookkeeping; the read data itself lives in the lane registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
            rsp_uns_reg   <= 1'b0;
            rsp_size_reg  <= 2'd0;
            rsp_off_reg   <= '0;
        end else begin
            rsp_valid_reg <= accept;
            rsp_err_reg   <= accept && req_err;
            rsp_load_reg  <= accept && !req_we;
            rsp_uns_reg   <= req_unsigned;
            rsp_size_reg  <= req_size;
            rsp_off_reg   <= eff_off;
        end
    end

    dmem_load_extend #(
        .XLEN (XLEN)
    ) u_extend (
        .word        (rd_word),
        .offset      (rsp_off_reg),
        .size        (rsp_size_reg),
        .is_unsigned (rsp_uns_reg),
        .data        (ext_data)
    );

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    // Data is only meaningful for successful loads; everything else reads 0.
    assign rsp_rdata = (rsp_valid_reg && rsp_load_reg && !rsp_err_reg) ? ext_data : '0;

    // High address bits wrap by design; mask bits above NB are unused at XLEN=32.
    logic unused_bits;
    assign unused_bits = ^{req_addr, full_mask};

endmodule

// File: tb/tb_sized_data_memory.sv
// -----------------------------------------------------------------------------
// tb_sized_data_memory
// Scoreboard bench for sized_data_memory at XLEN = 64, DEPTH = 16. The driver
// updates a byte-array reference model at issue time and queues the expected
// response; an independent monitor pops and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_sized_data_memory;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int BYTES = DEPTH * XLEN / 8;

    logic            clk;
    logic            rstn;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [BYTES];
    int         tests;
    int         fails;
    int         cyc;
    int         last_rsp_cyc;
    int         prev_rsp_cyc;
    int         rsp_count;

    sized_data_memory #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference behaviour: a flat byte array, address wraps modulo its size.
    function automatic void model_access(input logic we, input logic [63:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [63:0] wdata,
                                         output logic [63:0] rdata, output logic err);
        int a;
        int off;
        int base;
        int n;
        a     = int'(addr % 64'(BYTES));
        off   = a % 8;
        base  = a - off;
        n     = 1 << size;
        rdata = '0;
        err   = 1'b0;
`ifdef SIZED_DMEM_MISALIGN_TRAP_EN
        if ((off % n) != 0) begin
            err = 1'b1;
            return;
        end
`else
        off = off - (off % n);
`endif
        if (we) begin
            for (int i = 0; i < n; i++) model_mem[base + off + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rdata = rdata | (64'(model_mem[base + off + i]) << (8 * i));
            if (!uns && n < 8 && rdata[8*n-1]) rdata = rdata | (~64'd0 << (8 * n));
        end
    endfunction

    // Called just after a negedge; drives one request and leaves the bench at
    // the negedge following its acceptance.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL issue_ready: req_ready stayed 0, expected 1");
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        model_access(we, addr, size, uns, wdata, e.rdata, e.err);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Holds a load request through the clear sequence and counts the edges
    // until req_ready rises.
    task automatic wait_init();
        int n;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        check("init_edges", 64'(n), 64'(DEPTH));
        @(negedge clk);
    endtask

    // Monitor: compares each response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                rsp_count++;
                prev_rsp_cyc = last_rsp_cyc;
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding");
                end else begin
                    e = sb.pop_front();
                    $display("[TB] rsp %0d: rdata=%h err=%0b (expected %h / %0b)",
                             rsp_count, rsp_rdata, rsp_err, e.rdata, e.err);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else begin
                check("idle_rdata", rsp_rdata, 64'd0);
                check("idle_err", 64'(rsp_err), 64'd0);
            end
        end
    end

    initial begin
        #300000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        tests        = 0;
        fails        = 0;
        cyc          = 0;
        last_rsp_cyc = 0;
        prev_rsp_cyc = 0;
        rsp_count    = 0;
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;

        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_init();

        // Every word reads zero after the clear.
        for (int w = 0; w < DEPTH; w++) issue(1'b0, 64'(w * 8), 2'd3, 1'b0, 64'd0);

        // Byte store and extension.
        issue(1'b1, 64'h13, 2'd0, 1'b0, 64'hDEAD_BEEF_CAFE_0080);
        issue(1'b0, 64'h13, 2'd0, 1'b0, 64'd0);
        issue(1'b0, 64'h13, 2'd0, 1'b1, 64'd0);
        issue(1'b0, 64'h10, 2'd3, 1'b0, 64'd0);

        // Back-to-back store then wrapped load of the same word.
        issue(1'b1, 64'h08, 2'd3, 1'b0, 64'h1122_3344_5566_7788);
        issue(1'b0, 64'h88, 2'd2, 1'b1, 64'd0);
        @(negedge clk);
        check("b2b_consecutive", 64'(last_rsp_cyc - prev_rsp_cyc), 64'd1);

        // Misaligned half store.
        issue(1'b1, 64'h21, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
        issue(1'b0, 64'h20, 2'd3, 1'b0, 64'd0);
        issue(1'b0, 64'h20, 2'd1, 1'b0, 64'd0);

        // Randomized mix across the whole address space, high bits included.
        for (int k = 0; k < 400; k++) begin
            logic [63:0] a;
            logic [63:0] d;
            a = {32'($urandom), 32'($urandom)};
            d = {32'($urandom), 32'($urandom)};
            issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), d);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Reset arriving half a cycle before a store edge.
        issue(1'b0, 64'h30, 2'd3, 1'b0, 64'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'h30;
        req_size  = 2'd3;
        req_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
        rstn      = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd0);
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_init();
        issue(1'b0, 64'h30, 2'd3, 1'b0, 64'd0);
        issue(1'b0, 64'h08, 2'd3, 1'b0, 64'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Parametrised successor to the mini-cpu data memory: a byte-addressed, single-port, synchronous data RAM serving RISC-V loads and stores of byte/half/word/double size with sign or zero extension. It sits behind the execute stage and uses a valid/ready request and a one-cycle registered response. After every reset it runs a hardware clear sequence, so contents are defined zero before the first access; asynchronous reset alone cannot clear an array.

## Interface
- XLEN, 64: data width; legal values 32 or 64.
- DEPTH, 1024: number of XLEN-wide words; power of two ≥ 2.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  XLEN  byte address.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  input  1  zero-extend the load; ignored for stores.
- req_wdata  input  XLEN  store data, taken from the low bytes.
- rsp_valid  output  1  response pulse; one per accepted request.
- rsp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected as misaligned or illegal size.

## Operation
- Derived constants:
  - OFF = log2(XLEN/8).
  - AW = log2(DEPTH).
  - Word index = req_addr[OFF +: AW].
  - Byte offset = req_addr[OFF-1:0].
- Address bits above OFF+AW are ignored, so the address wraps modulo DEPTH·XLEN/8 bytes.
- State machine states:
  - INIT: the reset state, with clr_idx = 0. Each clock edge writes zero to word clr_idx and increments clr_idx. On the edge that writes DEPTH-1, the state goes to RUN. req_ready = 0.
  - RUN: req_ready = 1. A request is accepted when req_valid && req_ready.
- Store:
  - The byte lanes at offset..offset+2^size-1 are written from req_wdata[0 +: 8·2^size].
  - All other lanes are unchanged.
  - The write commits on the accepting edge.
- Load:
  - The word is read on the accepting edge.
  - The result is shifted right by 8·offset, truncated to 2^size bytes, then sign- or zero-extended to XLEN.
  - Size 3 always returns the full word.
- Illegal size: size 3 when XLEN = 32 is rejected with rsp_err = 1, independent of the configuration macro.
- Back-to-back: one request per cycle. A load on the cycle after a store to the same word returns the stored data.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = INIT, clr_idx = 0.
- req_ready first rises after exactly DEPTH clock edges with rstn high.
- Latency: rsp_valid is high exactly one cycle after the accepting edge, for one cycle. There is no response backpressure.
- rsp_rdata and rsp_err are valid only while rsp_valid = 1. They are 0 otherwise.
- Reset asserted mid-INIT: the sequence restarts from clr_idx = 0.
- Reset asserted in RUN:
  - All outputs clear immediately.
  - A store whose edge has not yet occurred is not committed.
  - Array contents are later overwritten by INIT.
- Requests presented during INIT are ignored. They are not queued.

## Configuration
- SIZED_DMEM_MISALIGN_TRAP_EN defined:
  - A request whose offset is not a multiple of 2^size is not performed: no array write.
  - Its response has rsp_err = 1 and rsp_rdata = 0.
- Macro undefined:
  - The offset's low size bits are forced to zero (natural alignment down) and the access is performed.
  - rsp_err is asserted only for an illegal size.

## Structure
- Package sized_dmem_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state enum (ST_INIT, ST_RUN);
  - a function giving the byte-mask for a given size and offset.
- Sub-module dmem_load_extend: purely combinational load shift, truncate and extend (inputs: word, offset, size, unsigned).

## Test plan
All scenarios use XLEN = 64 and DEPTH = 16 unless stated.
- Reset and clear:
  - Release rstn and hold req_valid = 1 → req_ready is 0 for 16 edges, then 1.
  - Load double at every word address 0x0..0x78 → every rsp_rdata = 0.
- Byte store and sign extension:
  - Store byte 0x80 at address 0x13 → load byte at 0x13 returns 0xFFFF_FFFF_FFFF_FF80.
  - Unsigned load byte at 0x13 returns 0x80.
  - Load double at 0x10 returns 0x0000_0000_8000_0000.
- Back-to-back and wrap:
  - Store double 0x1122_3344_5566_7788 at 0x08, then on the next cycle load word at 0x88 (wraps to 0x08) → rsp_rdata = 0x5566_7788.
  - rsp_valid is high on two consecutive cycles.
- Misaligned, macro defined:
  - Store half 0xBEEF at 0x21 → rsp_err = 1.
  - Load double at 0x20 returns 0.
- Misaligned, macro undefined:
  - Same store → rsp_err = 0.
  - Load half at 0x20 returns 0xFFFF_FFFF_FFFF_BEEF.
- Reset mid-operation:
  - Assert rstn = 0 half a cycle before a store edge, then release → after the 16-edge clear, a load of that address returns 0.
  - req_ready and rsp_valid drop to 0 immediately on assertion.
